note_player: RTL
================

Name: note_player

Overview:
- Playback-side counterpart of the guitar recorder. The recorder writes 32-bit string×fret note vectors into the 64x32 note RAM, one word per tempo tick.
- This block reads those words back at the same tempo and presents each one on note_out for display.
- It decodes each word to a pitch and generates a square-wave tone_out for the audio pin.
- It sits between the control FSM (which supplies start/stop pulses and the tempo tick) and the note RAM read port.

Parameters:
ADDR_W, 6, note RAM address width (64 words)
RD_LAT, 2, cycles from rd_addr change to valid rd_data
CLK_HZ, 50000000, clk frequency used to derive the tone half-period table

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin playback from address 0
stop  in  1  one-cycle pulse: abort playback
length  in  ADDR_W+1  number of recorded notes, 0..64
note_tick  in  1  one-cycle pulse per note period, from the clock divider
rd_addr  out  ADDR_W  note RAM read address
rd_data  in  32  note RAM read data
note_out  out  32  note currently playing; 0 when idle
tone_out  out  1  square-wave audio output
busy  out  1  high while playing
done  out  1  one-cycle pulse when playback completes naturally

Behaviour:
- Reset (async, any state): state=IDLE; rd_addr=0, note_out=0, tone_out=0, busy=0, done=0, tone counter=0.
- States: IDLE, FETCH, LOAD, PLAY.
- IDLE:
  - start with length!=0 -> FETCH; rd_addr=0, busy=1.
  - start with length==0 -> stay IDLE; done=1 for one cycle.
- FETCH: wait RD_LAT-1 cycles, then -> LOAD.
- LOAD (one cycle): note_out<=rd_data; reload the tone generator; -> PLAY.
- Timing: with start sampled at edge E0, note_out is updated at edge E0+RD_LAT.
- PLAY:
  - On note_tick, if rd_addr==length-1 -> IDLE: note_out=0, tone_out=0, busy=0, done=1 for one cycle.
  - On note_tick otherwise: rd_addr+1 -> FETCH. The previous note_out holds until the next LOAD.
- note_tick outside PLAY is ignored.
- start while busy is ignored.
- stop in any non-IDLE state -> IDLE next cycle: note_out=0, tone_out=0, busy=0, no done pulse. stop has priority over note_tick in the same cycle.
- Pitch decode:
  - k = lowest set bit index of note[29:0]; bits 31:30 are ignored; lowest index wins when several bits are set.
  - string s=k mod 6, fret f=k div 6.
  - Open-string MIDI numbers, s=0..5: 40, 45, 50, 55, 59, 64.
  - m = base[s]+f, range 40..68.
  - freq = 440*2^((m-69)/12); half_period = round(CLK_HZ/(2*freq)), 19 bits. Implemented as a constant 29-entry table.
- Tone generator:
  - On LOAD, tone_out=0 and the counter loads half_period-1.
  - Counter decrements each cycle; at 0 it toggles tone_out and reloads.
  - note[29:0]==0 is a rest: tone_out held 0, counter idle.
- rd_addr never exceeds length-1. length=64 plays addresses 0..63 with no wrap.
- length is sampled only when start is accepted. Changes to length mid-playback are ignored.

Test Plan:
- Reset mid-PLAY (rd_addr=5, tone toggling) -> all outputs 0 in the same cycle; IDLE after deassert; next start begins at address 0.
- RAM model holds word0=0x00000002 (A2) and word1=0x00000040 (E2, fret 1 = F2, m=41); length=2; start at E0 -> note_out=0x2 at E0+2; tone_out rises after 227273 cycles and toggles every 227273; tick -> rd_addr=1, note_out=0x40, half-period 286346; second tick -> done pulse, busy=0, note_out=0.
- length=0, start -> done high exactly one cycle, busy never asserts, rd_addr stays 0.
- word=0x00000000 in PLAY -> tone_out stays 0 across 1e6 cycles. word=0xC0000021 (bits 0 and 5) -> bit 0 wins, E2, half-period 303373.
- stop and note_tick asserted in the same PLAY cycle -> IDLE, no done pulse, rd_addr not incremented. start pulse while busy -> no restart.
- length=64 with ticks every 100 cycles -> rd_addr steps 0..63 in order, done after the 64th tick, no wrap to 0 before done.

Source files
------------

// File: rtl/note_player.sv
// rtl/note_player.sv - note RAM playback sequencer with pitch decode and square-wave tone generator
// Reads one note word per tempo tick, shows it on note_out and drives tone_out at its pitch.
module note_player #(
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2,
  parameter int CLK_HZ = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   length,
  input  logic              note_tick,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [31:0]       note_out,
  output logic              tone_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  localparam int FETCH_CYC = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam int FC_W      = $clog2(FETCH_CYC + 1);

  state_t          state, state_nxt;
  logic [FC_W-1:0] fetch_cnt;
  logic            fetch_done;
  logic [ADDR_W:0] len_q;
  logic [18:0]     tone_cnt, hp_m1;
  logic            rest;
  logic            accept, zero_start, finish, advance, last;
  logic [4:0]      dec_idx;
  logic            dec_rest;
  logic [18:0]     dec_hp;

  // Table entries are half-periods at 50 MHz; rescaled (rounded) for other clock rates.
  function automatic logic [18:0] scale_hp(input longint hp50);
    return 19'((hp50 * longint'(CLK_HZ) + 64'sd25000000) / 64'sd50000000);
  endfunction

  // Table offset of each open string relative to MIDI 40 (E2 A2 D3 G3 B3 E4).
  function automatic logic [4:0] open_off(input int s);
    case (s)
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd10;
      3:       return 5'd15;
      4:       return 5'd19;
      default: return 5'd24;
    endcase
  endfunction

  always_comb begin
    dec_idx = '0;
    for (int i = 29; i >= 0; i--)
      if (rd_data[i]) dec_idx = open_off(i % 6) + 5'(i / 6);
  end

  assign dec_rest = (rd_data[29:0] == 30'd0);

  always_comb begin
    case (dec_idx)
      5'd0:    dec_hp = scale_hp(303373);
      5'd1:    dec_hp = scale_hp(286346);
      5'd2:    dec_hp = scale_hp(270274);
      5'd3:    dec_hp = scale_hp(255105);
      5'd4:    dec_hp = scale_hp(240787);
      5'd5:    dec_hp = scale_hp(227273);
      5'd6:    dec_hp = scale_hp(214517);
      5'd7:    dec_hp = scale_hp(202477);
      5'd8:    dec_hp = scale_hp(191113);
      5'd9:    dec_hp = scale_hp(180386);
      5'd10:   dec_hp = scale_hp(170262);
      5'd11:   dec_hp = scale_hp(160706);
      5'd12:   dec_hp = scale_hp(151686);
      5'd13:   dec_hp = scale_hp(143173);
      5'd14:   dec_hp = scale_hp(135137);
      5'd15:   dec_hp = scale_hp(127553);
      5'd16:   dec_hp = scale_hp(120394);
      5'd17:   dec_hp = scale_hp(113636);
      5'd18:   dec_hp = scale_hp(107258);
      5'd19:   dec_hp = scale_hp(101238);
      5'd20:   dec_hp = scale_hp(95556);
      5'd21:   dec_hp = scale_hp(90193);
      5'd22:   dec_hp = scale_hp(85131);
      5'd23:   dec_hp = scale_hp(80353);
      5'd24:   dec_hp = scale_hp(75843);
      5'd25:   dec_hp = scale_hp(71586);
      5'd26:   dec_hp = scale_hp(67569);
      5'd27:   dec_hp = scale_hp(63776);
      default: dec_hp = scale_hp(60197);
    endcase
  end

  assign busy       = (state != IDLE);
  assign fetch_done = (fetch_cnt == FC_W'(FETCH_CYC - 1));
  assign last       = ({1'b0, rd_addr} == len_q - (ADDR_W+1)'(1));

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    zero_start = 1'b0;
    finish     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_nxt = FETCH;
            accept    = 1'b1;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      FETCH: if (fetch_done) state_nxt = LOAD;
      LOAD:  state_nxt = PLAY;
      PLAY: begin
        if (note_tick) begin
          if (last) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = FETCH;
            advance   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // stop outranks a coincident tick and never produces done
    if (stop && state != IDLE) begin
      state_nxt = IDLE;
      finish    = 1'b0;
      advance   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      len_q     <= '0;
      rd_addr   <= '0;
      note_out  <= '0;
      tone_out  <= 1'b0;
      tone_cnt  <= '0;
      hp_m1     <= '0;
      rest      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= zero_start | finish;
      if (state == FETCH) fetch_cnt <= fetch_cnt + FC_W'(1);
      else                fetch_cnt <= '0;
      if (accept) begin
        rd_addr <= '0;
        len_q   <= length;
      end else if (advance) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
      if (state != IDLE && state_nxt == IDLE) begin
        note_out <= '0;
        tone_out <= 1'b0;
        tone_cnt <= '0;
        rest     <= 1'b1;
      end else if (state == LOAD) begin
        note_out <= rd_data;
        tone_out <= 1'b0;
        hp_m1    <= dec_hp - 19'd1;
        tone_cnt <= dec_hp - 19'd1;
        rest     <= dec_rest;
      end else if (state != IDLE && !rest) begin
        if (tone_cnt == '0) begin
          tone_out <= ~tone_out;
          tone_cnt <= hp_m1;
        end else begin
          tone_cnt <= tone_cnt - 19'd1;
        end
      end
    end
  end

endmodule
